// File: rtl/der_org_pkg.sv
// Shared definitions for the drawing-engine origin update scheduler.
// State encoding, write-select and requester indices, default origin width.
package der_org_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } org_state_e;

    localparam logic WSEL_SORG = 1'b0;
    localparam logic WSEL_DORG = 1'b1;

    localparam int unsigned REQ_HB  = 0;
    localparam int unsigned REQ_DLP = 1;

    localparam int unsigned ORG_W_DEF = 32;

endpackage

// File: rtl/der_rr_arb2.sv
// Two-requester round-robin arbiter; grants at most one request per enabled cycle.
// Priority flips only when both requesters contend and a grant is issued.
module der_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // ptr_q = 0: requester 0 wins the next tie; 1: requester 1 wins.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        if (en) begin
            if (&req) begin
                gnt   = ptr_q ? 2'b10 : 2'b01;
                ptr_d = ~ptr_q;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/der_org_sched.sv
// Schedules host/DLP writes into origin shadow registers and commits both
// shadows atomically into the active origins while the engine is idle.
module der_org_sched
    import der_org_pkg::*;
#(
    parameter int unsigned ORG_W = ORG_W_DEF
) (
    input  logic             de_clk,
    input  logic             de_rst,
    input  logic             hb_req,
    input  logic             hb_wsel,
    input  logic [ORG_W-1:0] hb_wdata,
    input  logic             hb_commit,
    output logic             hb_ack,
    input  logic             dlp_req,
    input  logic             dlp_wsel,
    input  logic [ORG_W-1:0] dlp_wdata,
    input  logic             dlp_commit,
    output logic             dlp_ack,
    input  logic             eng_busy,
    output logic [ORG_W-1:0] mf_sorg_2,
    output logic [ORG_W-1:0] mf_dorg_2,
    output logic             prst,
    output logic             org_upd,
    output logic             pend
);

    org_state_e       state_q, state_d;
    logic [ORG_W-1:0] sorg_q, sorg_d;
    logic [ORG_W-1:0] dorg_q, dorg_d;
    logic [ORG_W-1:0] mf_sorg_q, mf_sorg_d;
    logic [ORG_W-1:0] mf_dorg_q, mf_dorg_d;
    logic             pend_q, pend_d;

    logic [1:0]       arb_req;
    logic [1:0]       gnt;
    logic             arb_en;
    logic             granted;
    logic             sel_dlp;
    logic             w_sel;
    logic             w_commit;
    logic [ORG_W-1:0] w_data;

    assign arb_req[REQ_HB]  = hb_req;
    assign arb_req[REQ_DLP] = dlp_req;
    // Acks are combinational, so reset must gate them explicitly.
    assign arb_en = (state_q == ST_ACCEPT) && !de_rst;

    der_rr_arb2 u_arb (
        .clk (de_clk),
        .rst (de_rst),
        .req (arb_req),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign hb_ack   = gnt[REQ_HB];
    assign dlp_ack  = gnt[REQ_DLP];
    assign granted  = |gnt;
    assign sel_dlp  = gnt[REQ_DLP];
    assign w_sel    = sel_dlp ? dlp_wsel   : hb_wsel;
    assign w_commit = sel_dlp ? dlp_commit : hb_commit;
    assign w_data   = sel_dlp ? dlp_wdata  : hb_wdata;

    always_comb begin
        state_d   = state_q;
        sorg_d    = sorg_q;
        dorg_d    = dorg_q;
        mf_sorg_d = mf_sorg_q;
        mf_dorg_d = mf_dorg_q;
        pend_d    = pend_q;
        case (state_q)
            ST_ACCEPT: begin
                if (granted) begin
                    pend_d = 1'b1;
                    if (w_sel == WSEL_DORG) begin
                        dorg_d = w_data;
                    end else begin
                        sorg_d = w_data;
                    end
                    if (w_commit) begin
                        state_d = eng_busy ? ST_WAIT : ST_COMMIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!eng_busy) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                mf_sorg_d = sorg_q;
                mf_dorg_d = dorg_q;
                pend_d    = 1'b0;
                state_d   = ST_ACCEPT;
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge de_clk or posedge de_rst) begin
        if (de_rst) begin
            state_q   <= ST_ACCEPT;
            sorg_q    <= '0;
            dorg_q    <= '0;
            mf_sorg_q <= '0;
            mf_dorg_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sorg_q    <= sorg_d;
            dorg_q    <= dorg_d;
            mf_sorg_q <= mf_sorg_d;
            mf_dorg_q <= mf_dorg_d;
            pend_q    <= pend_d;
        end
    end

    assign mf_sorg_2 = mf_sorg_q;
    assign mf_dorg_2 = mf_dorg_q;
    assign pend      = pend_q;
    assign prst      = (state_q == ST_COMMIT);
    assign org_upd   = (state_q == ST_COMMIT);

endmodule

// File: tb/tb_der_org_sched.sv
// Directed self-checking bench for der_org_sched: arbitration, commit latency,
// busy stalling, reset mid-WAIT and last-write-wins on the shadows.
module tb_der_org_sched;

    localparam int unsigned W = 32;

    logic         de_clk;
    logic         de_rst;
    logic         hb_req, hb_wsel, hb_commit, hb_ack;
    logic [W-1:0] hb_wdata;
    logic         dlp_req, dlp_wsel, dlp_commit, dlp_ack;
    logic [W-1:0] dlp_wdata;
    logic         eng_busy;
    logic [W-1:0] mf_sorg_2, mf_dorg_2;
    logic         prst, org_upd, pend;

    int checks = 0;
    int errors = 0;

    der_org_sched #(.ORG_W(W)) dut (
        .de_clk     (de_clk),
        .de_rst     (de_rst),
        .hb_req     (hb_req),
        .hb_wsel    (hb_wsel),
        .hb_wdata   (hb_wdata),
        .hb_commit  (hb_commit),
        .hb_ack     (hb_ack),
        .dlp_req    (dlp_req),
        .dlp_wsel   (dlp_wsel),
        .dlp_wdata  (dlp_wdata),
        .dlp_commit (dlp_commit),
        .dlp_ack    (dlp_ack),
        .eng_busy   (eng_busy),
        .mf_sorg_2  (mf_sorg_2),
        .mf_dorg_2  (mf_dorg_2),
        .prst       (prst),
        .org_upd    (org_upd),
        .pend       (pend)
    );

    initial de_clk = 1'b0;
    always #5 de_clk = ~de_clk;

    task automatic tick();
        @(posedge de_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        de_rst     = 1'b1;
        hb_req     = 1'b0; hb_wsel  = 1'b0; hb_wdata  = 'x; hb_commit  = 1'b0;
        dlp_req    = 1'b0; dlp_wsel = 1'b0; dlp_wdata = 'x; dlp_commit = 1'b0;
        eng_busy   = 1'b0;
        tick(); tick();
        de_rst = 1'b0;
        #1;
        chk("rst_mf_sorg", mf_sorg_2, 32'h0);
        chk("rst_mf_dorg", mf_dorg_2, 32'h0);
        chk("rst_pend", {31'b0, pend}, 32'h0);
        chk("rst_prst", {31'b0, prst}, 32'h0);
        tick();

        // Contention from reset: hb first, then dlp; next tie goes to dlp.
        hb_req = 1'b1;  hb_wsel = 1'b0;  hb_wdata = 32'hAAAA_0001;
        dlp_req = 1'b1; dlp_wsel = 1'b1; dlp_wdata = 32'hBBBB_0001;
        #1;
        chk("tie1_hb_ack", {31'b0, hb_ack}, 32'h1);
        chk("tie1_dlp_ack", {31'b0, dlp_ack}, 32'h0);
        tick();
        hb_req = 1'b0; hb_wdata = 'x;
        #1;
        chk("tie1_dlp_next", {31'b0, dlp_ack}, 32'h1);
        chk("tie1_hb_idle", {31'b0, hb_ack}, 32'h0);
        tick();
        dlp_req = 1'b0; dlp_wdata = 'x;
        chk("tie1_pend", {31'b0, pend}, 32'h1);
        tick();
        hb_req = 1'b1;  hb_wsel = 1'b0;  hb_wdata = 32'hAAAA_0002;
        dlp_req = 1'b1; dlp_wsel = 1'b1; dlp_wdata = 32'hBBBB_0002;
        #1;
        chk("tie2_dlp_ack", {31'b0, dlp_ack}, 32'h1);
        chk("tie2_hb_ack", {31'b0, hb_ack}, 32'h0);
        tick();
        dlp_req = 1'b0; dlp_wdata = 'x;
        #1;
        chk("tie2_hb_next", {31'b0, hb_ack}, 32'h1);
        tick();
        hb_req = 1'b0; hb_wdata = 'x;
        chk("tie_mf_sorg_frozen", mf_sorg_2, 32'h0);
        chk("tie_mf_dorg_frozen", mf_dorg_2, 32'h0);

        // hb sorg write, then dorg write with commit, engine idle.
        hb_req = 1'b1; hb_wsel = 1'b0; hb_wdata = 32'h0012_3450; hb_commit = 1'b0;
        #1;
        chk("wr_sorg_ack", {31'b0, hb_ack}, 32'h1);
        tick();
        hb_wsel = 1'b1; hb_wdata = 32'h0ABC_DEF0; hb_commit = 1'b1;
        #1;
        chk("wr_dorg_ack", {31'b0, hb_ack}, 32'h1);
        chk("wr_no_prst_yet", {31'b0, prst}, 32'h0);
        tick();
        hb_req = 1'b0; hb_wdata = 'x; hb_commit = 1'b0;
        #1;
        chk("cm_prst", {31'b0, prst}, 32'h1);
        chk("cm_org_upd", {31'b0, org_upd}, 32'h1);
        chk("cm_mf_sorg_old", mf_sorg_2, 32'h0);
        chk("cm_pend", {31'b0, pend}, 32'h1);
        tick();
        chk("post_prst", {31'b0, prst}, 32'h0);
        chk("post_org_upd", {31'b0, org_upd}, 32'h0);
        chk("post_mf_sorg", mf_sorg_2, 32'h0012_3450);
        chk("post_mf_dorg", mf_dorg_2, 32'h0ABC_DEF0);
        chk("post_pend", {31'b0, pend}, 32'h0);

        // dlp write+commit while busy; hb stalls in WAIT.
        eng_busy = 1'b1;
        dlp_req = 1'b1; dlp_wsel = 1'b0; dlp_wdata = 32'h1111_0000; dlp_commit = 1'b1;
        #1;
        chk("busy_dlp_ack", {31'b0, dlp_ack}, 32'h1);
        tick();
        dlp_req = 1'b0; dlp_wdata = 'x; dlp_commit = 1'b0;
        hb_req = 1'b1; hb_wsel = 1'b1; hb_wdata = 32'h2222_0000; hb_commit = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("wait_hb_ack", {31'b0, hb_ack}, 32'h0);
            chk("wait_prst", {31'b0, prst}, 32'h0);
            chk("wait_mf_sorg", mf_sorg_2, 32'h0012_3450);
            chk("wait_pend", {31'b0, pend}, 32'h1);
            tick();
        end
        eng_busy = 1'b0;
        #1;
        chk("wait_last_hb_ack", {31'b0, hb_ack}, 32'h0);
        tick();
        chk("busy_cm_prst", {31'b0, prst}, 32'h1);
        chk("busy_cm_hb_ack", {31'b0, hb_ack}, 32'h0);
        tick();
        chk("busy_acc_hb_ack", {31'b0, hb_ack}, 32'h1);
        chk("busy_mf_sorg", mf_sorg_2, 32'h1111_0000);
        chk("busy_mf_dorg", mf_dorg_2, 32'h0ABC_DEF0);
        tick();
        hb_req = 1'b0; hb_wdata = 'x;
        chk("busy_hb_pend", {31'b0, pend}, 32'h1);
        chk("busy_hb_no_commit", mf_dorg_2, 32'h0ABC_DEF0);

        // Reset asserted mid-WAIT discards the pending commit.
        eng_busy = 1'b1;
        dlp_req = 1'b1; dlp_wsel = 1'b1; dlp_wdata = 32'h3333_0000; dlp_commit = 1'b1;
        #1;
        chk("rw_dlp_ack", {31'b0, dlp_ack}, 32'h1);
        tick();
        dlp_req = 1'b0; dlp_wdata = 'x; dlp_commit = 1'b0;
        tick();
        de_rst = 1'b1;
        hb_req = 1'b1; hb_wsel = 1'b0; hb_wdata = 32'h5555_0000;
        #1;
        chk("rw_mf_sorg", mf_sorg_2, 32'h0);
        chk("rw_mf_dorg", mf_dorg_2, 32'h0);
        chk("rw_pend", {31'b0, pend}, 32'h0);
        chk("rw_hb_ack", {31'b0, hb_ack}, 32'h0);
        chk("rw_prst", {31'b0, prst}, 32'h0);
        tick();
        de_rst = 1'b0; hb_req = 1'b0; hb_wdata = 'x; eng_busy = 1'b0;
        tick();
        chk("rel_prst1", {31'b0, prst}, 32'h0);
        tick();
        chk("rel_prst2", {31'b0, prst}, 32'h0);
        chk("rel_mf_sorg", mf_sorg_2, 32'h0);
        chk("rel_mf_dorg", mf_dorg_2, 32'h0);

        // Eight back-to-back dlp writes to sorg; last one wins at commit.
        dlp_req = 1'b1; dlp_wsel = 1'b0; dlp_commit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dlp_wdata = 32'hD000_0000 + i;
            #1;
            chk("b2b_dlp_ack", {31'b0, dlp_ack}, 32'h1);
            tick();
        end
        dlp_req = 1'b0; dlp_wdata = 'x;
        chk("b2b_mf_sorg", mf_sorg_2, 32'h0);
        chk("b2b_pend", {31'b0, pend}, 32'h1);
        hb_req = 1'b1; hb_wsel = 1'b1; hb_wdata = 32'h4444_0000; hb_commit = 1'b1;
        #1;
        chk("b2b_hb_ack", {31'b0, hb_ack}, 32'h1);
        tick();
        hb_req = 1'b0; hb_wdata = 'x; hb_commit = 1'b0;
        tick();
        chk("b2b_mf_sorg_last", mf_sorg_2, 32'hD000_0007);
        chk("b2b_mf_dorg", mf_dorg_2, 32'h4444_0000);
        chk("b2b_pend_clr", {31'b0, pend}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
